// File: rtl/axis_dense_pkg.sv
// axis_dense_pkg
//   Shared types and helpers for the axis_dense_q fully-connected layer.
//   - state_t   : controller states
//   - clog2     : ceiling log2 for sizing counters and accumulators
//   - sat_round : round-half-up, shift out the fraction, saturate to data_w
package axis_dense_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    XLOAD,
    COMPUTE,
    FINISH,
    OUTPUT
  } state_t;

  // Working widths for sat_round; large enough for any practical
  // accumulator (2*DATA_W + clog2(N_IN)) and result.
  localparam int ACC_MAX_W = 128;
  localparam int RES_MAX_W = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // acc is a Q(2*FRAC_W) value, sign-extended to ACC_MAX_W by the caller.
  // Returns the Q(FRAC_W) result clamped to a data_w-bit signed range;
  // the caller keeps the low data_w bits.
  function automatic logic signed [RES_MAX_W-1:0] sat_round(
      input logic signed [ACC_MAX_W-1:0] acc,
      input int                          frac_w,
      input int                          data_w);
    logic signed [ACC_MAX_W-1:0] half;
    logic signed [ACC_MAX_W-1:0] rnd;
    logic signed [ACC_MAX_W-1:0] hi;
    logic signed [ACC_MAX_W-1:0] lo;
    half = $signed({{(ACC_MAX_W-1){1'b0}}, 1'b1}) <<< (frac_w - 1);
    rnd  = acc + half;
    rnd  = rnd >>> frac_w;
    lo   = $signed({ACC_MAX_W{1'b1}}) <<< (data_w - 1);
    hi   = ~lo;
    if (rnd > hi) begin
      rnd = hi;
    end else if (rnd < lo) begin
      rnd = lo;
    end
    return rnd[RES_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/axis_dense_q_mac.sv
// dense_mac
//   Registered multiplier feeding a wide accumulator.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     mul_en       : register a*b into the product stage
//     load_bias    : acc <= bias << FRAC_W (start of a row)
//     acc_en       : acc <= acc + registered product
//     a, b         : signed operands (activation, weight)
//     bias         : signed row bias
//     acc          : accumulator, Q(2*FRAC_W)
module dense_mac
  import axis_dense_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_IN   = 20,
  parameter int FRAC_W = 16,
  parameter int ACC_W  = 2 * DATA_W + clog2(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mul_en,
  input  logic                     load_bias,
  input  logic                     acc_en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      acc    <= '0;
    end else begin
      if (mul_en) begin
        prod_q <= a * b;
      end
      if (load_bias) begin
        acc <= {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};
      end else if (acc_en) begin
        acc <= acc + {{(ACC_W-2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q};
      end
    end
  end

endmodule

// File: rtl/axis_dense_q.sv
// axis_dense_q
//   Fully-connected layer y = W*x + b over AXI4-Stream, signed Q(FRAC_W).
//   Weight frames (TUSER=1) carry N_OUT rows of N_IN weights plus bias;
//   activation frames (TUSER=0) carry N_IN words and trigger N_OUT results.
//   Ports:
//     aclk, areset        : clock, synchronous active-high reset
//     INPUT_AXIS_*        : weight/bias or activation stream in
//     OUTPUT_AXIS_*       : result stream out, TLAST on y[N_OUT-1]
//     relu_en             : clamp negative results, latched per activation frame
//     err_frame           : one-cycle pulse on a malformed input frame
//
//   state   | meaning
//   IDLE    | ready for first word; TUSER picks the frame type
//   WLOAD   | writing weight/bias words row-major
//   XLOAD   | writing activation words
//   COMPUTE | bias load + one MAC per cycle for row j (N_IN+1 cycles)
//   FINISH  | round/saturate/ReLU, register result
//   OUTPUT  | hold result until the output handshake
module axis_dense_q
  import axis_dense_pkg::*;
#(
  parameter int N_IN   = 20,
  parameter int N_OUT  = 10,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] INPUT_AXIS_TDATA,
  input  logic              INPUT_AXIS_TUSER,
  input  logic              INPUT_AXIS_TLAST,
  input  logic              INPUT_AXIS_TVALID,
  output logic              INPUT_AXIS_TREADY,
  output logic [DATA_W-1:0] OUTPUT_AXIS_TDATA,
  output logic              OUTPUT_AXIS_TLAST,
  output logic              OUTPUT_AXIS_TVALID,
  input  logic              OUTPUT_AXIS_TREADY,
  input  logic              relu_en,
  output logic              err_frame
);

  localparam int ACC_W = 2 * DATA_W + clog2(N_IN);
  localparam int CW    = clog2(N_IN + 1);
  localparam int IW    = clog2(N_IN);
  localparam int RW    = (N_OUT > 1) ? clog2(N_OUT) : 1;

  logic signed [DATA_W-1:0] w_ram [N_OUT][N_IN];
  logic signed [DATA_W-1:0] b_ram [N_OUT];
  logic signed [DATA_W-1:0] x_buf [N_IN];

  state_t          state;
  logic            ftype;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   cnt_q;
  logic            relu_q;

  logic            accept;
  logic            cur_type;
  logic            type_err;
  logic            wr_ok;
  logic            w_we;
  logic            b_we;
  logic            x_we;
  logic            last_word;
  logic            last_row;

  logic            mul_en;
  logic            load_bias;
  logic            acc_en;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_MAX_W-1:0] acc_ext;
  logic signed [DATA_W-1:0]    result;

  always_comb begin
    accept    = INPUT_AXIS_TVALID && INPUT_AXIS_TREADY && !areset &&
                (state == IDLE || state == WLOAD || state == XLOAD);
    cur_type  = (state == IDLE) ? INPUT_AXIS_TUSER : ftype;
    type_err  = accept && (state != IDLE) && (INPUT_AXIS_TUSER != ftype);
    wr_ok     = accept && !type_err;
    w_we      = wr_ok && cur_type && (col_q != CW'(N_IN));
    b_we      = wr_ok && cur_type && (col_q == CW'(N_IN));
    x_we      = wr_ok && !cur_type;
    last_row  = (row_q == RW'(N_OUT - 1));
    last_word = cur_type ? (last_row && col_q == CW'(N_IN))
                         : (col_q == CW'(N_IN - 1));
  end

  always_ff @(posedge aclk) begin
    if (w_we) w_ram[row_q][col_q[IW-1:0]] <= INPUT_AXIS_TDATA;
    if (b_we) b_ram[row_q] <= INPUT_AXIS_TDATA;
    if (x_we) x_buf[col_q[IW-1:0]] <= INPUT_AXIS_TDATA;
  end

  // MAC schedule per row: cnt 0 loads the bias and issues product 0,
  // cnt 1..N_IN-1 accumulate product i-1 and issue product i, cnt N_IN
  // drains the last product.
  always_comb begin
    load_bias = (state == COMPUTE) && (cnt_q == '0);
    mul_en    = (state == COMPUTE) && (cnt_q != CW'(N_IN));
    acc_en    = (state == COMPUTE) && (cnt_q != '0);
  end

  dense_mac #(
    .DATA_W (DATA_W),
    .N_IN   (N_IN),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk       (aclk),
    .rst       (areset),
    .mul_en    (mul_en),
    .load_bias (load_bias),
    .acc_en    (acc_en),
    .a         (x_buf[cnt_q[IW-1:0]]),
    .b         (w_ram[row_q][cnt_q[IW-1:0]]),
    .bias      (b_ram[row_q]),
    .acc       (acc)
  );

  assign acc_ext = {{(ACC_MAX_W-ACC_W){acc[ACC_W-1]}}, acc};

  always_comb begin
    result = DATA_W'(sat_round(acc_ext, FRAC_W, DATA_W));
    if (relu_q && result[DATA_W-1]) begin
      result = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state              <= IDLE;
      ftype              <= 1'b0;
      col_q              <= '0;
      row_q              <= '0;
      cnt_q              <= '0;
      relu_q             <= 1'b0;
      INPUT_AXIS_TREADY  <= 1'b0;
      OUTPUT_AXIS_TDATA  <= '0;
      OUTPUT_AXIS_TLAST  <= 1'b0;
      OUTPUT_AXIS_TVALID <= 1'b0;
      err_frame          <= 1'b0;
    end else begin
      err_frame <= 1'b0;
      case (state)
        IDLE, WLOAD, XLOAD: begin
          if (state == IDLE) begin
            INPUT_AXIS_TREADY <= 1'b1;
          end
          if (type_err) begin
            // Mismatched word is dropped and the frame abandoned.
            err_frame <= 1'b1;
            state     <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
          end else if (accept) begin
            ftype <= cur_type;
            if (last_word) begin
              // A missing TLAST is flagged, but the full frame is still used.
              err_frame <= !INPUT_AXIS_TLAST;
              col_q     <= '0;
              row_q     <= '0;
              if (cur_type) begin
                state <= IDLE;
              end else begin
                state             <= COMPUTE;
                INPUT_AXIS_TREADY <= 1'b0;
                cnt_q             <= '0;
                relu_q            <= relu_en;
              end
            end else if (INPUT_AXIS_TLAST) begin
              err_frame <= 1'b1;
              state     <= IDLE;
              col_q     <= '0;
              row_q     <= '0;
            end else begin
              state <= cur_type ? WLOAD : XLOAD;
              if (cur_type && col_q == CW'(N_IN)) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
        end

        COMPUTE: begin
          if (cnt_q == CW'(N_IN)) begin
            cnt_q <= '0;
            state <= FINISH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        FINISH: begin
          OUTPUT_AXIS_TDATA  <= result;
          OUTPUT_AXIS_TVALID <= 1'b1;
          OUTPUT_AXIS_TLAST  <= last_row;
          state              <= OUTPUT;
        end

        OUTPUT: begin
          if (OUTPUT_AXIS_TREADY) begin
            OUTPUT_AXIS_TVALID <= 1'b0;
            OUTPUT_AXIS_TLAST  <= 1'b0;
            if (last_row) begin
              state             <= IDLE;
              row_q             <= '0;
              INPUT_AXIS_TREADY <= 1'b1;
            end else begin
              row_q <= row_q + 1'b1;
              state <= COMPUTE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_dense_q.sv
module tb_axis_dense_q;

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] TWO  = 32'h0002_0000;
  localparam logic [31:0] HALF = 32'h0000_8000;
  localparam logic [31:0] M1   = 32'hFFFF_0000;
  localparam logic [31:0] M10  = 32'hFFF6_0000;
  localparam logic [31:0] BIGP = 32'h7FFF_0000;
  localparam logic [31:0] BIGN = 32'h8000_0000;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] in_data;
  logic        in_user, in_last, in_valid, in_ready;
  logic [31:0] out_data;
  logic        out_last, out_valid, out_ready;
  logic        relu_en, err_frame;

  logic [31:0] b_in_data;
  logic        b_in_user, b_in_last, b_in_valid, b_in_ready;
  logic [31:0] b_out_data;
  logic        b_out_last, b_out_valid, b_out_ready;
  logic        b_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] wv [10];
  logic [31:0] xv [4];

  always #5 aclk = ~aclk;

  axis_dense_q #(.N_IN(4), .N_OUT(2), .DATA_W(32), .FRAC_W(16)) dut (
    .aclk               (aclk),
    .areset             (areset),
    .INPUT_AXIS_TDATA   (in_data),
    .INPUT_AXIS_TUSER   (in_user),
    .INPUT_AXIS_TLAST   (in_last),
    .INPUT_AXIS_TVALID  (in_valid),
    .INPUT_AXIS_TREADY  (in_ready),
    .OUTPUT_AXIS_TDATA  (out_data),
    .OUTPUT_AXIS_TLAST  (out_last),
    .OUTPUT_AXIS_TVALID (out_valid),
    .OUTPUT_AXIS_TREADY (out_ready),
    .relu_en            (relu_en),
    .err_frame          (err_frame)
  );

  axis_dense_q dut_big (
    .aclk               (aclk),
    .areset             (areset),
    .INPUT_AXIS_TDATA   (b_in_data),
    .INPUT_AXIS_TUSER   (b_in_user),
    .INPUT_AXIS_TLAST   (b_in_last),
    .INPUT_AXIS_TVALID  (b_in_valid),
    .INPUT_AXIS_TREADY  (b_in_ready),
    .OUTPUT_AXIS_TDATA  (b_out_data),
    .OUTPUT_AXIS_TLAST  (b_out_last),
    .OUTPUT_AXIS_TVALID (b_out_valid),
    .OUTPUT_AXIS_TREADY (b_out_ready),
    .relu_en            (1'b0),
    .err_frame          (b_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on a falling edge with err_frame
  // as it stands right after this word's handshake.
  task automatic send_word(input logic [31:0] d, input logic u, input logic l, output logic e);
    int n;
    in_data  = d;
    in_user  = u;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("in_ready_wait", 64'(n < 50), 64'd1);
    @(posedge aclk);
    @(negedge aclk);
    e        = err_frame;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_user  = 1'b0;
  endtask

  task automatic load_w(output logic e);
    for (int i = 0; i < 10; i++) send_word(wv[i], 1'b1, i == 9, e);
  endtask

  task automatic send_x(output logic e);
    for (int i = 0; i < 4; i++) send_word(xv[i], 1'b0, i == 3, e);
  endtask

  task automatic recv(input string tag, input logic [31:0] ed, input logic el);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(out_data), 64'(ed));
    check({tag, "_last"}, 64'(out_last), 64'(el));
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      if (out_valid) seen++;
      @(posedge aclk);
      @(negedge aclk);
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  task automatic set_basic_w();
    wv = '{ONE, ONE, ONE, ONE, 32'h0, HALF, M1, 32'h0, TWO, ONE};
  endtask

  initial begin
    logic        e;
    int          beats, n, cycles;
    logic        held, done, done_next;
    logic [31:0] hold_d;
    logic [31:0] got [2];
    logic        gl  [2];

    areset = 1'b1;
    in_data = '0; in_user = 1'b0; in_last = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; relu_en = 1'b0;
    b_in_data = '0; b_in_user = 1'b0; b_in_last = 1'b0; b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    xv = '{ONE, TWO, 32'h0003_0000, 32'h0004_0000};
    set_basic_w();

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_tready", 64'(in_ready), 64'd0);
    check("rst_tvalid", 64'(out_valid), 64'd0);
    check("rst_tlast", 64'(out_last), 64'd0);
    check("rst_tdata", 64'(out_data), 64'd0);
    check("rst_err", 64'(err_frame), 64'd0);
    areset = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("rst_tready_rise", 64'(in_ready), 64'd1);

    // Basic
    load_w(e);
    check("basic_wload_err", 64'(e), 64'd0);
    send_x(e);
    check("basic_xload_err", 64'(e), 64'd0);
    recv("basic_y0", 32'h000A_0000, 1'b0);
    recv("basic_y1", 32'h0007_8000, 1'b1);
    quiet("basic_extra_beats", 10);

    // Backpressure: TREADY toggles every cycle
    send_x(e);
    out_ready = 1'b0;
    beats = 0;
    held = 1'b0;
    hold_d = '0;
    for (int c = 0; c < 60; c++) begin
      out_ready = ~out_ready;
      if (out_valid) begin
        if (held) check("bp_stable", 64'(out_data), 64'(hold_d));
        if (out_ready) begin
          if (beats < 2) begin
            got[beats] = out_data;
            gl[beats]  = out_last;
          end
          beats++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          hold_d = out_data;
        end
      end
      @(posedge aclk);
      @(negedge aclk);
    end
    out_ready = 1'b1;
    check("bp_beats", 64'(beats), 64'd2);
    check("bp_y0", 64'(got[0]), 64'h000A_0000);
    check("bp_y1", 64'(got[1]), 64'h0007_8000);
    check("bp_last0", 64'(gl[0]), 64'd0);
    check("bp_last1", 64'(gl[1]), 64'd1);

    // Early TLAST on an activation frame
    send_word(ONE, 1'b0, 1'b0, e);
    check("early_w0_err", 64'(e), 64'd0);
    send_word(TWO, 1'b0, 1'b0, e);
    send_word(32'h0003_0000, 1'b0, 1'b1, e);
    check("early_err_pulse", 64'(e), 64'd1);
    @(posedge aclk);
    @(negedge aclk);
    check("early_err_one_cycle", 64'(err_frame), 64'd0);
    quiet("early_no_output", 15);
    send_x(e);
    recv("after_err_y0", 32'h000A_0000, 1'b0);
    recv("after_err_y1", 32'h0007_8000, 1'b1);

    // Reset while y0 is waiting in OUTPUT
    out_ready = 1'b0;
    send_x(e);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check("mid_rst_y0_valid", 64'(out_valid), 64'd1);
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check("mid_rst_tvalid", 64'(out_valid), 64'd0);
    check("mid_rst_tready", 64'(in_ready), 64'd0);
    areset = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("mid_rst_tready_rise", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send_x(e);
    recv("post_rst_y0", 32'h000A_0000, 1'b0);
    recv("post_rst_y1", 32'h0007_8000, 1'b1);

    // ReLU: row1 = 6.5 - 10.0 = -3.5
    set_basic_w();
    wv[9] = M10;
    load_w(e);
    relu_en = 1'b0;
    send_x(e);
    recv("relu_off_y0", 32'h000A_0000, 1'b0);
    recv("relu_off_y1", 32'hFFFC_8000, 1'b1);
    relu_en = 1'b1;
    send_x(e);
    recv("relu_on_y0", 32'h000A_0000, 1'b0);
    recv("relu_on_y1", 32'h0000_0000, 1'b1);
    relu_en = 1'b0;

    // Saturation
    wv = '{BIGP, BIGP, BIGP, BIGP, 32'h0, BIGP, BIGP, BIGP, BIGP, 32'h0};
    xv = '{BIGP, BIGP, BIGP, BIGP};
    load_w(e);
    send_x(e);
    recv("sat_pos_y0", 32'h7FFF_FFFF, 1'b0);
    recv("sat_pos_y1", 32'h7FFF_FFFF, 1'b1);
    wv = '{BIGN, BIGN, BIGN, BIGN, 32'h0, BIGN, BIGN, BIGN, BIGN, 32'h0};
    load_w(e);
    send_x(e);
    recv("sat_neg_y0", 32'h8000_0000, 1'b0);
    recv("sat_neg_y1", 32'h8000_0000, 1'b1);

    // Weight frame with a stray activation word
    send_word(ONE, 1'b1, 1'b0, e);
    check("wtype_w0_err", 64'(e), 64'd0);
    send_word(ONE, 1'b1, 1'b0, e);
    send_word(ONE, 1'b0, 1'b0, e);
    check("wtype_err_pulse", 64'(e), 64'd1);
    check("wtype_back_idle", 64'(in_ready), 64'd1);
    quiet("wtype_no_output", 10);

    // Default 20x10: last input handshake to last output handshake
    for (int i = 0; i < 20; i++) begin
      b_in_data  = 32'(i) << 16;
      b_in_last  = (i == 19);
      b_in_valid = 1'b1;
      n = 0;
      while (!b_in_ready && n < 50) begin
        @(negedge aclk);
        n++;
      end
      check("big_ready_wait", 64'(n < 50), 64'd1);
      @(posedge aclk);
      @(negedge aclk);
    end
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
    cycles = 0;
    done = 1'b0;
    done_next = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (b_out_valid && b_out_last) done_next = 1'b1;
      @(posedge aclk);
      cycles++;
      if (done_next) done = 1'b1;
      @(negedge aclk);
    end
    check("big_last_seen", 64'(done), 64'd1);
    check("big_cycles", 64'(cycles), 64'd230);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
